// File: rtl/dogx_pkg.sv
// Shared types and helpers for the VCO difference window counter: accumulator
// sizing, signed clipping and the per-channel window result record.
package dogx_pkg;

    localparam int REC_W = 32;

    typedef struct packed {
        logic signed [REC_W-1:0] diff;
        logic                    sat;
    } diff_rec_t;

    // Wide enough to hold DECIM full-scale deltas without wrapping.
    function automatic int acc_width(input int lsb_bits, input int decim);
        return lsb_bits + $clog2(decim);
    endfunction

    function automatic diff_rec_t sat_signed(input logic signed [REC_W-1:0] value,
                                             input int out_w);
        logic signed [REC_W-1:0] hi;
        logic signed [REC_W-1:0] lo;
        diff_rec_t               rec;
        hi       = (32'sd1 <<< (out_w - 1)) - 32'sd1;
        lo       = -hi - 32'sd1;
        rec.diff = value;
        rec.sat  = 1'b0;
        if (value > hi) begin
            rec.diff = hi;
            rec.sat  = 1'b1;
        end else if (value < lo) begin
            rec.diff = lo;
            rec.sat  = 1'b1;
        end
        return rec;
    endfunction

endpackage

// File: rtl/vco_delta_accum.sv
// One oscillator side of one channel: wrap-aware delta from the previous sample,
// gated window accumulator and free-running extended count.
module vco_delta_accum #(
    parameter int LSB_BITS = 5,
    parameter int EXT_BITS = 4,
    parameter int ACC_W    = 8
) (
    input  logic                         CLK_24M,
    input  logic                         reset,
    input  logic                         prime,
    input  logic                         win_close,
    input  logic                         enable,
    input  logic [LSB_BITS-1:0]          count,
    output logic [ACC_W-1:0]             acc_sum,
    output logic [LSB_BITS+EXT_BITS-1:0] ext_count
);

    localparam int EXT_W = LSB_BITS + EXT_BITS;

    logic [LSB_BITS-1:0] prev_reg;
    logic [LSB_BITS-1:0] delta;
    logic [ACC_W-1:0]    acc_reg;
    logic [ACC_W-1:0]    acc_next;
    logic [EXT_W-1:0]    ext_reg;
    logic [EXT_W-1:0]    ext_next;

    // Modular subtraction absorbs the wrap of the incoming count.
    always_comb begin
        delta    = count - prev_reg;
        acc_sum  = enable ? (acc_reg + ACC_W'(delta)) : '0;
        acc_next = (prime || win_close) ? '0 : acc_sum;
        ext_next = prime ? ext_reg : (ext_reg + EXT_W'(delta));
    end

    always_ff @(posedge CLK_24M or negedge reset) begin
        if (!reset) begin
            prev_reg <= '0;
            acc_reg  <= '0;
            ext_reg  <= '0;
        end else begin
            prev_reg <= count;
            acc_reg  <= acc_next;
            ext_reg  <= ext_next;
        end
    end

    assign ext_count = ext_reg;

endmodule

// File: rtl/vco_diff_window_counter.sv
// Multi-channel VCO count extender: integrates p and n deltas over DECIM-cycle
// windows and presents the clipped p-minus-n difference through valid/ready.
module vco_diff_window_counter
    import dogx_pkg::*;
#(
    parameter int N_CH     = 2,
    parameter int LSB_BITS = 5,
    parameter int EXT_BITS = 4,
    parameter int DECIM    = 8,
    parameter int OUT_W    = 11
) (
    input  logic                                CLK_24M,
    input  logic                                reset,
    input  logic [N_CH*LSB_BITS-1:0]            count_p,
    input  logic [N_CH*LSB_BITS-1:0]            count_n,
    input  logic [N_CH-1:0]                     ch_enable,
    input  logic                                out_ready,
    output logic [N_CH*OUT_W-1:0]               diff_out,
    output logic                                out_valid,
    output logic [N_CH-1:0]                     sat_flag,
    output logic                                overrun,
    output logic [N_CH*(LSB_BITS+EXT_BITS)-1:0] ext_count_p
);

    localparam int ACC_W = acc_width(LSB_BITS, DECIM);
    localparam int CNT_W = $clog2(DECIM);
    localparam int EXT_W = LSB_BITS + EXT_BITS;

    logic             prime_reg;
    logic [CNT_W-1:0] win_cnt_reg;
    logic [CNT_W-1:0] win_cnt_next;
    logic             win_close;

    logic [ACC_W-1:0]        acc_p_sum [N_CH];
    logic [ACC_W-1:0]        acc_n_sum [N_CH];
    logic [EXT_W-1:0]        ext_n_unused [N_CH];
    logic [N_CH*OUT_W-1:0]   win_diff;
    logic [N_CH-1:0]         win_sat;

    logic [N_CH*OUT_W-1:0]   data_reg;
    logic [N_CH*OUT_W-1:0]   data_next;
    logic [N_CH-1:0]         sat_reg;
    logic [N_CH-1:0]         sat_next;
    logic                    valid_reg;
    logic                    valid_next;
    logic                    overrun_reg;
    logic                    overrun_next;

    // The prime edge only seeds prev; the first counted sample is the next edge.
    assign win_close = !prime_reg && (win_cnt_reg == CNT_W'(DECIM - 1));

    always_comb begin
        win_cnt_next = win_cnt_reg + CNT_W'(1);
        if (prime_reg || win_close) begin
            win_cnt_next = '0;
        end
    end

    always_ff @(posedge CLK_24M or negedge reset) begin
        if (!reset) begin
            prime_reg   <= 1'b1;
            win_cnt_reg <= '0;
        end else begin
            prime_reg   <= 1'b0;
            win_cnt_reg <= win_cnt_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic signed [ACC_W:0] diff_full;
            diff_rec_t             rec;
            logic                  rec_unused;

            vco_delta_accum #(
                .LSB_BITS (LSB_BITS),
                .EXT_BITS (EXT_BITS),
                .ACC_W    (ACC_W)
            ) u_p (
                .CLK_24M   (CLK_24M),
                .reset     (reset),
                .prime     (prime_reg),
                .win_close (win_close),
                .enable    (ch_enable[gi]),
                .count     (count_p[gi*LSB_BITS +: LSB_BITS]),
                .acc_sum   (acc_p_sum[gi]),
                .ext_count (ext_count_p[gi*EXT_W +: EXT_W])
            );

            vco_delta_accum #(
                .LSB_BITS (LSB_BITS),
                .EXT_BITS (EXT_BITS),
                .ACC_W    (ACC_W)
            ) u_n (
                .CLK_24M   (CLK_24M),
                .reset     (reset),
                .prime     (prime_reg),
                .win_close (win_close),
                .enable    (ch_enable[gi]),
                .count     (count_n[gi*LSB_BITS +: LSB_BITS]),
                .acc_sum   (acc_n_sum[gi]),
                .ext_count (ext_n_unused[gi])
            );

            // A disabled channel presents zero on both sums, so its diff is zero.
            assign diff_full  = $signed({1'b0, acc_p_sum[gi]}) - $signed({1'b0, acc_n_sum[gi]});
            assign rec        = sat_signed({{(REC_W-ACC_W-1){diff_full[ACC_W]}}, diff_full}, OUT_W);
            assign rec_unused = ^rec.diff[REC_W-1:OUT_W];
            assign win_diff[gi*OUT_W +: OUT_W] = rec.diff[OUT_W-1:0];
            assign win_sat[gi] = rec.sat;
        end
    endgenerate

    // Held data wins over a new window while the consumer stalls.
    always_comb begin
        data_next    = data_reg;
        sat_next     = sat_reg;
        valid_next   = valid_reg;
        overrun_next = overrun_reg;
        if (valid_reg && out_ready) begin
            valid_next = 1'b0;
        end
        if (win_close) begin
            if (!valid_reg || out_ready) begin
                data_next  = win_diff;
                sat_next   = win_sat;
                valid_next = 1'b1;
            end else begin
                overrun_next = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_24M or negedge reset) begin
        if (!reset) begin
            data_reg    <= '0;
            sat_reg     <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            data_reg    <= data_next;
            sat_reg     <= sat_next;
            valid_reg   <= valid_next;
            overrun_reg <= overrun_next;
        end
    end

    assign diff_out  = data_reg;
    assign sat_flag  = sat_reg;
    assign out_valid = valid_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_vco_diff_window_counter.sv
// Scoreboard bench: stimulus pushes hand-computed window results, a monitor
// pops and compares on every accepted output; debug outputs checked directly.
module tb_vco_diff_window_counter;

    localparam int N_CH     = 2;
    localparam int LSB_BITS = 5;
    localparam int EXT_BITS = 4;
    localparam int DECIM    = 8;
    localparam int OUT_W    = 6;
    localparam int EXT_W    = LSB_BITS + EXT_BITS;

    typedef struct {
        int d0;
        int s0;
        int d1;
        int s1;
    } exp_t;

    logic                       CLK_24M = 1'b0;
    logic                       reset = 1'b0;
    logic [N_CH*LSB_BITS-1:0]   count_p = '0;
    logic [N_CH*LSB_BITS-1:0]   count_n = '0;
    logic [N_CH-1:0]            ch_enable = 2'b11;
    logic                       out_ready = 1'b1;
    logic [N_CH*OUT_W-1:0]      diff_out;
    logic                       out_valid;
    logic [N_CH-1:0]            sat_flag;
    logic                       overrun;
    logic [N_CH*EXT_W-1:0]      ext_count_p;

    logic [LSB_BITS-1:0] cp0 = '0, cp1 = '0, cn0 = '0, cn1 = '0;
    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_fail = 0;

    vco_diff_window_counter #(
        .N_CH     (N_CH),
        .LSB_BITS (LSB_BITS),
        .EXT_BITS (EXT_BITS),
        .DECIM    (DECIM),
        .OUT_W    (OUT_W)
    ) dut (
        .CLK_24M     (CLK_24M),
        .reset       (reset),
        .count_p     (count_p),
        .count_n     (count_n),
        .ch_enable   (ch_enable),
        .out_ready   (out_ready),
        .diff_out    (diff_out),
        .out_valid   (out_valid),
        .sat_flag    (sat_flag),
        .overrun     (overrun),
        .ext_count_p (ext_count_p)
    );

    always #5 CLK_24M = ~CLK_24M;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic drive();
        count_p = {cp1, cp0};
        count_n = {cn1, cn0};
    endtask

    task automatic tick();
        @(posedge CLK_24M);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, int'(out_valid), 0);
        check({tag, "_diff"}, int'(diff_out), 0);
        check({tag, "_sat"}, int'(sat_flag), 0);
        check({tag, "_overrun"}, int'(overrun), 0);
        check({tag, "_ext"}, int'(ext_count_p), 0);
    endtask

    // Release reset with the given starting counts; the following edge primes.
    task automatic release_reset(input int p0, input int p1, input int n0, input int n1);
        cp0 = LSB_BITS'(p0);
        cp1 = LSB_BITS'(p1);
        cn0 = LSB_BITS'(n0);
        cn1 = LSB_BITS'(n1);
        drive();
        reset = 1'b1;
        tick();
    endtask

    task automatic run_window(input int sp0, input int sn0, input int sp1, input int sn1,
                              input int e0, input int s0, input int e1, input int s1,
                              input bit push, input logic [1:0] en_val, input int en_cyc,
                              input bit rdy_val, input bit rdy_pulse, input bit chk_lat);
        exp_t e;
        e.d0 = e0;
        e.s0 = s0;
        e.d1 = e1;
        e.s1 = s1;
        if (push) exp_q.push_back(e);
        for (int i = 0; i < DECIM; i++) begin
            if (i == en_cyc) ch_enable = en_val;
            if (i == 1) out_ready = rdy_val;
            if (rdy_pulse && i == DECIM - 1) out_ready = 1'b1;
            cp0 = cp0 + LSB_BITS'(sp0);
            cn0 = cn0 + LSB_BITS'(sn0);
            cp1 = cp1 + LSB_BITS'(sp1);
            cn1 = cn1 + LSB_BITS'(sn1);
            drive();
            tick();
            if (chk_lat && i == DECIM - 2) check("latency_not_yet", int'(out_valid), 0);
            if (chk_lat && i == DECIM - 1) check("latency_first_valid", int'(out_valid), 1);
        end
        if (rdy_pulse) begin
            check("valid_stays_on_close_transfer", int'(out_valid), 1);
            out_ready = rdy_val;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK_24M);
            if (reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got diff0=%0d diff1=%0d, required no output",
                             $signed(diff_out[OUT_W-1:0]), $signed(diff_out[2*OUT_W-1:OUT_W]));
                end else begin
                    e = exp_q.pop_front();
                    check("win_diff0", int'($signed(diff_out[OUT_W-1:0])), e.d0);
                    check("win_sat0", int'(sat_flag[0]), e.s0);
                    check("win_diff1", int'($signed(diff_out[2*OUT_W-1:OUT_W])), e.d1);
                    check("win_sat1", int'(sat_flag[1]), e.s1);
                end
            end
        end
    end

    initial begin : stimulus
        repeat (2) tick();
        check_all_zero("reset");
        release_reset(0, 0, 0, 0);

        // p +3 / n +1 and p +2 / n +5 per cycle
        for (int w = 0; w < 3; w++) begin
            run_window(3, 1, 2, 5, 16, 0, -24, 0, 1'b1, 2'b11, 0, 1'b1, 1'b0, 1'b0);
        end
        check("ext_p0_after_24", int'(ext_count_p[EXT_W-1:0]), 72);
        check("ext_p1_after_24", int'(ext_count_p[2*EXT_W-1:EXT_W]), 48);

        // step 4 across the 5-bit wrap; extended count wraps at 512
        tick();
        reset = 1'b0;
        repeat (2) tick();
        release_reset(24, 0, 0, 0);
        for (int w = 1; w <= 17; w++) begin
            run_window(4, 4, 0, 0, 0, 0, 0, 0, 1'b1, 2'b11, 0, 1'b1, 1'b0, 1'b0);
            if (w == 1)  check("ext_w1", int'(ext_count_p[EXT_W-1:0]), 32);
            if (w == 15) check("ext_w15", int'(ext_count_p[EXT_W-1:0]), 480);
            if (w == 16) check("ext_wrap", int'(ext_count_p[EXT_W-1:0]), 0);
            if (w == 17) check("ext_after_wrap", int'(ext_count_p[EXT_W-1:0]), 32);
        end

        // saturation at OUT_W=6: [-32, 31]
        run_window(31, 0, 0, 31, 31, 1, -32, 1, 1'b1, 2'b11, 0, 1'b1, 1'b0, 1'b0);
        run_window(0, 31, 31, 0, -32, 1, 31, 1, 1'b1, 2'b11, 0, 1'b1, 1'b0, 1'b0);
        run_window(4, 0, 3, 7, 31, 1, -32, 0, 1'b1, 2'b11, 0, 1'b1, 1'b0, 1'b0);
        run_window(31, 28, 0, 0, 24, 0, 0, 0, 1'b1, 2'b11, 0, 1'b1, 1'b0, 1'b0);

        // back-pressure: hold, drop, load-on-transfer
        run_window(1, 0, 1, 2, 8, 0, -8, 0, 1'b1, 2'b11, 0, 1'b0, 1'b0, 1'b0);
        check("overrun_clear", int'(overrun), 0);
        check("held_valid", int'(out_valid), 1);
        run_window(2, 0, 0, 0, 16, 0, 0, 0, 1'b0, 2'b11, 0, 1'b0, 1'b0, 1'b0);
        check("overrun_set", int'(overrun), 1);
        check("held_data_kept", int'($signed(diff_out[OUT_W-1:0])), 8);
        run_window(3, 0, 0, 1, 24, 0, -8, 0, 1'b1, 2'b11, 0, 1'b0, 1'b1, 1'b0);
        run_window(1, 1, 1, 1, 0, 0, 0, 0, 1'b1, 2'b11, 0, 1'b1, 1'b0, 1'b0);

        // channel enable: ch1 off, then re-enabled before sample 4
        run_window(2, 1, 31, 0, 8, 0, 0, 0, 1'b1, 2'b01, 0, 1'b1, 1'b0, 1'b0);
        run_window(2, 1, 3, 1, 8, 0, 8, 0, 1'b1, 2'b11, 4, 1'b1, 1'b0, 1'b0);
        run_window(0, 3, 3, 1, -24, 0, 16, 0, 1'b1, 2'b11, 0, 1'b1, 1'b0, 1'b0);
        check("overrun_sticky", int'(overrun), 1);

        // reset three samples into a window
        for (int i = 0; i < 3; i++) begin
            cp0 = cp0 + 5'd1;
            cp1 = cp1 + 5'd2;
            drive();
            tick();
        end
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) tick();
        release_reset(7, 3, 9, 2);
        run_window(1, 0, 2, 2, 8, 0, 0, 0, 1'b1, 2'b11, 0, 1'b1, 1'b0, 1'b1);
        check("ext_p0_post_prime", int'(ext_count_p[EXT_W-1:0]), 8);
        check("ext_p1_post_prime", int'(ext_count_p[2*EXT_W-1:EXT_W]), 16);

        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
